// File: rtl/click_flood.sv
// ---------------------------------------------------------------------------
// click_flood : minesweeper board-state engine with stack-based flood reveal
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module click_flood #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int MINES = 10,
  parameter int XW    = $clog2(COLS),
  parameter int YW    = $clog2(ROWS),
  parameter int CW    = $clog2(ROWS*COLS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [XW-1:0] load_x,
  input  logic [YW-1:0] load_y,
  input  logic [3:0]    load_val,
  input  logic          select,
  input  logic          flag,
  input  logic [XW-1:0] pos_x,
  input  logic [YW-1:0] pos_y,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic [5:0]    rd_cell,
  output logic          busy,
  output logic          done,
  output logic          game_over,
  output logic          win,
  output logic [CW-1:0] revealed_cnt
);

  localparam int N      = ROWS * COLS;
  localparam int IW     = $clog2(N);
  localparam int TARGET = N - MINES;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_POP   = 3'd2,
    S_SCAN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [3:0]       content [N];
  logic [N-1:0]     revealed;
  logic [N-1:0]     flagged;
  logic [YW+XW-1:0] stack [N];
  logic [CW-1:0]    sp;
  logic [XW-1:0]    cur_x;
  logic [YW-1:0]    cur_y;
  logic [2:0]       dir;

  function automatic logic [IW-1:0] cell_idx(input logic [YW-1:0] y, input logic [XW-1:0] x);
    return IW'(int'(y) * COLS + int'(x));
  endfunction

  // Neighbour coordinates carry two spare bits so -1 wraps to a value that fails the bounds test.
  logic [XW+1:0] nx, dx;
  logic [YW+1:0] ny, dy;
  logic          n_inb, n_open, n_push;
  logic [IW-1:0] n_idx, p_idx, l_idx, r_idx, c_idx;
  logic          pos_ok, load_ok, rd_ok;
  logic [CW-1:0] sp_next;

  always_comb begin
    dx = '0;
    dy = '0;
    case (dir)
      3'd0, 3'd3, 3'd5: dx = '1;
      3'd2, 3'd4, 3'd7: dx = (XW+2)'(1);
      default:          dx = '0;
    endcase
    case (dir)
      3'd0, 3'd1, 3'd2: dy = '1;
      3'd5, 3'd6, 3'd7: dy = (YW+2)'(1);
      default:          dy = '0;
    endcase
    nx      = {2'b00, cur_x} + dx;
    ny      = {2'b00, cur_y} + dy;
    n_inb   = (int'(nx) < COLS) && (int'(ny) < ROWS);
    n_idx   = cell_idx(ny[YW-1:0], nx[XW-1:0]);
    n_open  = n_inb && !revealed[n_idx] && !flagged[n_idx];
    n_push  = n_open && (content[n_idx] == 4'd0);
    sp_next = n_push ? sp + CW'(1) : sp;
  end

  assign pos_ok  = (int'(pos_x) < COLS) && (int'(pos_y) < ROWS);
  assign load_ok = (int'(load_x) < COLS) && (int'(load_y) < ROWS);
  assign rd_ok   = (int'(rd_x) < COLS) && (int'(rd_y) < ROWS);
  assign p_idx   = cell_idx(pos_y, pos_x);
  assign l_idx   = cell_idx(load_y, load_x);
  assign r_idx   = cell_idx(rd_y, rd_x);
  assign c_idx   = cell_idx(cur_y, cur_x);
  assign rd_cell = rd_ok ? {flagged[r_idx], revealed[r_idx], content[r_idx]} : 6'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        content[i] <= 4'd0;
        stack[i]   <= '0;
      end
      revealed     <= '0;
      flagged      <= '0;
      sp           <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
      dir          <= '0;
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      game_over    <= 1'b0;
      win          <= 1'b0;
      revealed_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_en) begin
            if (load_ok) begin
              content[l_idx]  <= load_val;
              revealed[l_idx] <= 1'b0;
              flagged[l_idx]  <= 1'b0;
            end
            if (game_over || win) begin
              game_over    <= 1'b0;
              win          <= 1'b0;
              revealed_cnt <= '0;
            end
          end else if ((select || flag) && !game_over && !win) begin
            cur_x <= pos_x;
            cur_y <= pos_y;
            busy  <= 1'b1;
            if (!pos_ok) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (select) begin
              if (flagged[p_idx] || revealed[p_idx]) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_CHECK;
              end
            end else begin
              if (!revealed[p_idx])
                flagged[p_idx] <= ~flagged[p_idx];
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          revealed[c_idx] <= 1'b1;
          revealed_cnt    <= revealed_cnt + CW'(1);
          if (content[c_idx] == 4'hF) begin
            game_over <= 1'b1;
            state     <= S_DONE;
            done      <= 1'b1;
          end else begin
            if (int'(revealed_cnt) + 1 == TARGET)
              win <= 1'b1;
            if (content[c_idx] == 4'd0) begin
              stack[0] <= {cur_y, cur_x};
              sp       <= CW'(1);
              state    <= S_POP;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_POP: begin
          {cur_y, cur_x} <= stack[IW'(sp - CW'(1))];
          sp             <= sp - CW'(1);
          dir            <= '0;
          state          <= S_SCAN;
        end
        S_SCAN: begin
          // Marking at push time guarantees each cell enters the stack at most once.
          if (n_open) begin
            revealed[n_idx] <= 1'b1;
            revealed_cnt    <= revealed_cnt + CW'(1);
            if (int'(revealed_cnt) + 1 == TARGET)
              win <= 1'b1;
          end
          if (n_push)
            stack[IW'(sp)] <= {ny[YW-1:0], nx[XW-1:0]};
          sp  <= sp_next;
          dir <= dir + 3'd1;
          if (dir == 3'd7) begin
            if (sp_next == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_POP;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_click_flood.sv
// ---------------------------------------------------------------------------
// tb_click_flood : directed self-checking bench for click_flood (8x8, MINES=1)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_click_flood;

  logic       clk = 1'b0;
  logic       rst, load_en, select, flag;
  logic [2:0] load_x, load_y, pos_x, pos_y, rd_x, rd_y;
  logic [3:0] load_val;
  logic [5:0] rd_cell;
  logic       busy, done, game_over, win;
  logic [6:0] revealed_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  click_flood #(.ROWS(8), .COLS(8), .MINES(1)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_x(load_x), .load_y(load_y),
    .load_val(load_val), .select(select), .flag(flag), .pos_x(pos_x), .pos_y(pos_y),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell), .busy(busy), .done(done),
    .game_over(game_over), .win(win), .revealed_cnt(revealed_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_cell(input logic [2:0] x, input logic [2:0] y, input logic [3:0] v);
    load_en = 1'b1; load_x = x; load_y = y; load_val = v;
    tick();
    load_en = 1'b0;
  endtask

  task automatic cmd(input bit is_sel, input logic [2:0] x, input logic [2:0] y);
    pos_x = x; pos_y = y;
    if (is_sel) select = 1'b1; else flag = 1'b1;
    tick();
    select = 1'b0; flag = 1'b0;
  endtask

  task automatic read_cell(input logic [2:0] x, input logic [2:0] y, output logic [5:0] c);
    rd_x = x; rd_y = y;
    #1;
    c = rd_cell;
  endtask

  task automatic load_board();
    load_cell(3'd7, 3'd7, 4'hF);
    load_cell(3'd6, 3'd6, 4'd1);
    load_cell(3'd6, 3'd7, 4'd1);
    load_cell(3'd7, 3'd6, 4'd1);
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int nz;
    logic [5:0] c;
    do_reset();
    checks++;
    if ({busy, done, game_over, win} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, game_over, win});
    end
    checks++;
    if (revealed_cnt !== 7'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", revealed_cnt);
    end
    nz = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        read_cell(3'(x), 3'(y), c);
        if (c !== 6'd0) nz++;
      end
    checks++;
    if (nz != 0) begin
      errors++; $display("FAIL reset_cells: got %0d nonzero cells want 0", nz);
    end
  endtask

  task automatic test_flag();
    logic [5:0] c;
    cmd(1'b0, 3'd3, 3'd4);
    read_cell(3'd3, 3'd4, c);
    checks++;
    if (done !== 1'b1 || c !== 6'b10_0000) begin
      errors++; $display("FAIL flag_set: got done=%b cell=%b want done=1 cell=100000", done, c);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flag_done_width: got done=%b busy=%b want 0 0", done, busy);
    end
    cmd(1'b0, 3'd3, 3'd4);
    read_cell(3'd3, 3'd4, c);
    checks++;
    if (c !== 6'b00_0000) begin
      errors++; $display("FAIL flag_clear: got %b want 000000", c);
    end
    tick();
    cmd(1'b0, 3'd3, 3'd4);
    tick();
    cmd(1'b1, 3'd3, 3'd4);
    read_cell(3'd3, 3'd4, c);
    checks++;
    if (done !== 1'b1 || c !== 6'b10_0000 || revealed_cnt !== 7'd0) begin
      errors++; $display("FAIL select_flagged: got done=%b cell=%b cnt=%0d want 1 100000 0", done, c, revealed_cnt);
    end
    tick();
    cmd(1'b0, 3'd3, 3'd4);
    tick();
  endtask

  task automatic test_reveal_count();
    logic [5:0] c;
    load_cell(3'd2, 3'd2, 4'd2);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL load_no_done: got done=%b busy=%b want 0 0", done, busy);
    end
    cmd(1'b1, 3'd2, 3'd2);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL reveal_lat1: got done=%b busy=%b want 0 1", done, busy);
    end
    tick();
    read_cell(3'd2, 3'd2, c);
    checks++;
    if (done !== 1'b1 || c !== 6'b01_0010 || revealed_cnt !== 7'd1) begin
      errors++; $display("FAIL reveal_count: got done=%b cell=%b cnt=%0d want 1 010010 1", done, c, revealed_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reveal_idle: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_mine();
    logic [5:0] c;
    load_cell(3'd5, 3'd5, 4'hF);
    cmd(1'b1, 3'd5, 3'd5);
    tick();
    checks++;
    if (done !== 1'b1 || game_over !== 1'b1) begin
      errors++; $display("FAIL mine_hit: got done=%b game_over=%b want 1 1", done, game_over);
    end
    tick();
    cmd(1'b1, 3'd0, 3'd0);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL over_ignore: got busy=%b done=%b want 0 0", busy, done);
    end
    tick();
    read_cell(3'd0, 3'd0, c);
    checks++;
    if (done !== 1'b0 || c !== 6'd0 || revealed_cnt !== 7'd2) begin
      errors++; $display("FAIL over_state: got done=%b cell=%b cnt=%0d want 0 000000 2", done, c, revealed_cnt);
    end
  endtask

  task automatic test_flood_win();
    logic [5:0] c;
    bit ok;
    do_reset();
    load_board();
    cmd(1'b1, 3'd0, 3'd0);
    wait_done(3000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL flood_timeout: got no done want done within 3000 cycles");
    end
    checks++;
    if (revealed_cnt !== 7'd63 || win !== 1'b1 || game_over !== 1'b0) begin
      errors++; $display("FAIL flood_win: got cnt=%0d win=%b over=%b want 63 1 0", revealed_cnt, win, game_over);
    end
    read_cell(3'd7, 3'd7, c);
    checks++;
    if (c !== 6'b00_1111) begin
      errors++; $display("FAIL flood_mine_hidden: got %b want 001111", c);
    end
    read_cell(3'd6, 3'd6, c);
    checks++;
    if (c !== 6'b01_0001) begin
      errors++; $display("FAIL flood_border: got %b want 010001", c);
    end
    read_cell(3'd7, 3'd0, c);
    checks++;
    if (c !== 6'b01_0000) begin
      errors++; $display("FAIL flood_far: got %b want 010000", c);
    end
    tick();
    cmd(1'b1, 3'd7, 3'd7);
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || game_over !== 1'b0) begin
      errors++; $display("FAIL win_ignore: got busy=%b done=%b over=%b want 0 0 0", busy, done, game_over);
    end
    load_cell(3'd0, 3'd0, 4'd0);
    read_cell(3'd0, 3'd0, c);
    checks++;
    if (win !== 1'b0 || revealed_cnt !== 7'd0 || c !== 6'd0) begin
      errors++; $display("FAIL load_after_win: got win=%b cnt=%0d cell=%b want 0 0 000000", win, revealed_cnt, c);
    end
  endtask

  task automatic test_flag_block();
    logic [5:0] c;
    bit ok;
    do_reset();
    load_board();
    cmd(1'b0, 3'd0, 3'd3);
    tick();
    cmd(1'b1, 3'd0, 3'd0);
    wait_done(3000, ok);
    checks++;
    if (!ok || revealed_cnt !== 7'd62 || win !== 1'b0) begin
      errors++; $display("FAIL flag_block: got ok=%b cnt=%0d win=%b want 1 62 0", ok, revealed_cnt, win);
    end
    read_cell(3'd0, 3'd3, c);
    checks++;
    if (c !== 6'b10_0000) begin
      errors++; $display("FAIL flag_block_cell: got %b want 100000", c);
    end
    read_cell(3'd0, 3'd4, c);
    checks++;
    if (c !== 6'b01_0000) begin
      errors++; $display("FAIL flag_block_route: got %b want 010000", c);
    end
  endtask

  task automatic test_reset_mid_flood();
    logic [5:0] c;
    int nz;
    bit ok;
    do_reset();
    load_board();
    cmd(1'b1, 3'd0, 3'd0);
    repeat (20) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_flood_busy: got %b want 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || revealed_cnt !== 7'd0) begin
      errors++; $display("FAIL abort: got busy=%b done=%b cnt=%0d want 0 0 0", busy, done, revealed_cnt);
    end
    nz = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        read_cell(3'(x), 3'(y), c);
        if (c !== 6'd0) nz++;
      end
    checks++;
    if (nz != 0) begin
      errors++; $display("FAIL abort_cells: got %0d nonzero cells want 0", nz);
    end
    load_board();
    cmd(1'b1, 3'd0, 3'd0);
    wait_done(3000, ok);
    checks++;
    if (!ok || win !== 1'b1 || revealed_cnt !== 7'd63) begin
      errors++; $display("FAIL rerun: got ok=%b win=%b cnt=%0d want 1 1 63", ok, win, revealed_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; select = 1'b0; flag = 1'b0;
    load_x = '0; load_y = '0; load_val = '0;
    pos_x = '0; pos_y = '0; rd_x = '0; rd_y = '0;
    test_reset();
    test_flag();
    test_reveal_count();
    test_mine();
    test_flood_win();
    test_flag_block();
    test_reset_mid_flood();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
